// File: rtl/switch_debounce.sv
// Per-bit synchronizer plus stability-counter debouncer for raw slide switches.
// sw_out is the accepted level; changed pulses for one cycle after each accepted transition.
module switch_debounce #(
    parameter int WIDTH           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] changed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Stage 0 is the LSB of each chain; the MSB is the synchronized level.
    logic [SYNC_STAGES-1:0] sync [WIDTH];
    logic [CNT_W-1:0]       cnt  [WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                sync[i] <= '0;
                cnt[i]  <= '0;
            end
            sw_out  <= '0;
            changed <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                sync[i]    <= {sync[i][SYNC_STAGES-2:0], sw_in[i]};
                changed[i] <= 1'b0;
                // Any return to the accepted level discards partial progress.
                if (sync[i][SYNC_STAGES-1] == sw_out[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    sw_out[i]  <= sync[i][SYNC_STAGES-1];
                    cnt[i]     <= '0;
                    changed[i] <= 1'b1;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce: directed scenarios then random bouncing,
// compared against a sliding-window reference model over the recorded input history.
module tb_switch_debounce;

    localparam int W    = 2;
    localparam int S    = 2;
    localparam int D    = 4;
    localparam int MAXE = 8192;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw_in = '0;
    logic [W-1:0] sw_out;
    logic [W-1:0] changed;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    logic         hist_rst [MAXE];
    logic [W-1:0] hist_in  [MAXE];
    logic [W-1:0] model_out = '0;
    logic [W-1:0] model_chg = '0;

    switch_debounce #(
        .WIDTH(W),
        .SYNC_STAGES(S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_in(sw_in),
        .sw_out(sw_out),
        .changed(changed)
    );

    always #5 clk = ~clk;

    // Level the debouncer sees at edge t: the raw sample from S edges earlier,
    // or 0 if a reset within those edges cleared the chain.
    function automatic logic seen(int t, int b);
        for (int k = 1; k <= S; k++) begin
            if (t - k < 0) return 1'b0;
            if (hist_rst[t-k]) return 1'b0;
        end
        return hist_in[t-S][b];
    endfunction

    // A bit flips when the last D seen levels, all on non-reset edges, differ from it.
    task automatic update_model();
        int t;
        logic accept;
        t = edge_n;
        hist_rst[t] = rst;
        hist_in[t]  = sw_in;
        if (rst) begin
            model_out = '0;
            model_chg = '0;
        end else begin
            for (int b = 0; b < W; b++) begin
                accept = 1'b1;
                for (int k = 0; k < D; k++) begin
                    if (t - k < 0) accept = 1'b0;
                    else if (hist_rst[t-k]) accept = 1'b0;
                    else if (seen(t - k, b) == model_out[b]) accept = 1'b0;
                end
                model_chg[b] = accept;
                if (accept) model_out[b] = ~model_out[b];
            end
        end
        edge_n++;
    endtask

    task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s at edge %0d: observed %b expected %b", tag, edge_n, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic [W-1:0] v);
        rst   = r;
        sw_in = v;
        @(posedge clk);
        update_model();
        #1;
        check_output("model_sw_out", sw_out, model_out);
        check_output("model_changed", changed, model_chg);
    endtask

    task automatic hold(input logic [W-1:0] v, input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, v);
    endtask

    task automatic clean_reset();
        apply_stimulus(1'b1, 2'b00);
        hold(2'b00, 3);
    endtask

    initial begin
        logic [7:0] burst;
        int seg_len;
        logic [W-1:0] seg_val;
        logic seg_rst;

        for (int i = 0; i < MAXE; i++) begin
            hist_rst[i] = 1'b0;
            hist_in[i]  = '0;
        end

        // Reset held with switches up, then released.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 2'b11);
            check_output("reset_sw_out", sw_out, 2'b00);
            check_output("reset_changed", changed, 2'b00);
        end
        hold(2'b11, 5);
        check_output("post_reset_early", sw_out, 2'b00);
        hold(2'b11, 1);
        check_output("post_reset_sw_out", sw_out, 2'b11);
        check_output("post_reset_changed", changed, 2'b11);
        hold(2'b11, 1);
        check_output("post_reset_pulse_end", changed, 2'b00);

        // Clean step on bit 0.
        clean_reset();
        hold(2'b01, 5);
        check_output("step_early", sw_out, 2'b00);
        hold(2'b01, 1);
        check_output("step_sw_out", sw_out, 2'b01);
        check_output("step_changed", changed, 2'b01);
        hold(2'b01, 1);
        check_output("step_pulse_end", changed, 2'b00);

        // Bounce shorter than the debounce window is rejected.
        clean_reset();
        burst = 8'b1110_1101;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, {1'b0, burst[i]});
            check_output("bounce_changed", changed, 2'b00);
        end
        hold(2'b00, 6);
        check_output("bounce_sw_out", sw_out, 2'b00);

        // Bounce followed by a settled high.
        clean_reset();
        burst = 8'b0000_1101;
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, {1'b0, burst[i]});
        hold(2'b01, 5);
        check_output("settle_early", sw_out, 2'b00);
        hold(2'b01, 1);
        check_output("settle_sw_out", sw_out, 2'b01);
        check_output("settle_changed", changed, 2'b01);

        // Both bits together, then only bit 0 falls.
        clean_reset();
        hold(2'b11, 5);
        check_output("simul_early", sw_out, 2'b00);
        hold(2'b11, 1);
        check_output("simul_sw_out", sw_out, 2'b11);
        check_output("simul_changed", changed, 2'b11);
        hold(2'b11, 1);
        check_output("simul_pulse_end", changed, 2'b00);
        hold(2'b10, 5);
        check_output("fall_early", sw_out, 2'b11);
        hold(2'b10, 1);
        check_output("fall_sw_out", sw_out, 2'b10);
        check_output("fall_changed", changed, 2'b01);

        // Reset in the middle of a count restarts the full latency.
        clean_reset();
        hold(2'b10, 3);
        apply_stimulus(1'b1, 2'b10);
        hold(2'b10, 5);
        check_output("midreset_early", sw_out, 2'b00);
        hold(2'b10, 1);
        check_output("midreset_sw_out", sw_out, 2'b10);
        check_output("midreset_changed", changed, 2'b10);

        // Random bouncing segments with occasional resets.
        for (int seg = 0; seg < 400; seg++) begin
            seg_len = int'($urandom_range(1, 8));
            seg_val = W'($urandom_range(0, 3));
            seg_rst = ($urandom_range(0, 59) == 0);
            if (seg_rst) apply_stimulus(1'b1, seg_val);
            hold(seg_val, seg_len);
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
